// File: rtl/fifo_arb_pkg.sv
// Shared constants and sizing helpers for the FIFO push arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fifo_arb_pkg;

    // Width of the free-running accepted-push counter.
    localparam int PUSH_CNT_W = 16;

    // Ceiling log2 usable in constant expressions; clog2(1) = 0.
    function automatic int clog2(input int n);
        for (int r = 0; r < 31; r++) begin
            if ((1 << r) >= n) begin
                return r;
            end
        end
        return 31;
    endfunction

    // Requester index width, never narrower than one bit.
    function automatic int id_width(input int n);
        return (n < 2) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating first-one finder: first asserted req at or after start, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller qualifies the result.
//
// Ports:
//   req   - request vector, one bit per requester
//   start - index at which the search begins (must be < N)
//   found - at least one req bit is set
//   idx   - index of the selected requester (0 when found=0)
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic          found,
    output logic [IW-1:0] idx
);

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] s, input int k);
        int j;
        j = int'(s) + k;
        if (j >= N) begin
            j = j - N;
        end
        return IW'(j);
    endfunction

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[wrap_add(start, k)]) begin
                found = 1'b1;
                idx   = wrap_add(start, k);
            end
        end
    end

endmodule

// File: rtl/fifo_push_arb.sv
// Round-robin arbiter steering N requesters into one shared FIFO push port.
// Latency: zero; grant and push data are combinational from req and state.
// Backpressure: fifo_full=1 blocks all grants; requesters simply hold req.
//
// Ports:
//   clk, rstn          - rising-edge clock, async active-low reset
//   req / wdata        - per-requester push request and packed data
//   gnt                - one-hot grant, push accepted the cycle it is 1
//   fifo_full          - downstream FIFO full flag
//   fifo_push/wd/id    - push strobe, data and source index to the FIFO
//   push_cnt           - accepted pushes, wraps at 2^16
// Build option: define FIFO_PUSH_ARB_BURST_EN to let an owner keep the grant
// for up to MAX_BURST consecutive pushes; otherwise rotate after every push.
module fifo_push_arb
    import fifo_arb_pkg::*;
#(
    parameter  int N_REQ     = 4,
    parameter  int WIDTH     = 8,
    parameter  int MAX_BURST = 4,
    localparam int ID_W      = id_width(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] wdata,
    output logic [N_REQ-1:0]       gnt,
    input  logic                   fifo_full,
    output logic                   fifo_push,
    output logic [WIDTH-1:0]       fifo_wd,
    output logic [ID_W-1:0]        fifo_id,
    output logic [PUSH_CNT_W-1:0]  push_cnt
);

    if (N_REQ < 2 || N_REQ > 16 || MAX_BURST < 1 || MAX_BURST > 16) begin : g_bad_param
        $error("fifo_push_arb: N_REQ must be 2..16 and MAX_BURST 1..16");
    end

    logic [ID_W-1:0] last_owner;
    logic [ID_W-1:0] start_idx;
    logic [ID_W-1:0] pick_idx;
    logic [ID_W-1:0] sel_idx;
    logic            pick_found;
    logic            sel_vld;
    logic            push;

    // Search begins one past the last owner, wrapping at N_REQ-1.
    assign start_idx = (last_owner == ID_W'(N_REQ - 1)) ? '0 : last_owner + 1'b1;

    rr_pick #(
        .N  (N_REQ),
        .IW (ID_W)
    ) u_pick (
        .req   (req),
        .start (start_idx),
        .found (pick_found),
        .idx   (pick_idx)
    );

`ifdef FIFO_PUSH_ARB_BURST_EN
    localparam int BC_W = clog2(MAX_BURST + 1);

    logic [BC_W-1:0] burst_cnt;
    logic            owner_vld;
    logic            keep;

    // The owner keeps the grant while it still requests and has budget left.
    assign keep    = owner_vld && req[last_owner] && (burst_cnt < BC_W'(MAX_BURST));
    assign sel_idx = keep ? last_owner : pick_idx;
    assign sel_vld = keep | pick_found;

    // A full-stalled owner that still requests keeps both ownership and count;
    // an owner that drops req ends its burst so the next pick rotates past it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            burst_cnt <= '0;
            owner_vld <= 1'b0;
        end else if (push) begin
            owner_vld <= 1'b1;
            burst_cnt <= keep ? burst_cnt + 1'b1 : BC_W'(1);
        end else if (!req[last_owner]) begin
            owner_vld <= 1'b0;
            burst_cnt <= '0;
        end
    end
`else
    assign sel_idx = pick_idx;
    assign sel_vld = pick_found;
`endif

    // rstn gates the strobe so nothing escapes while reset is held.
    assign push      = sel_vld & ~fifo_full & rstn;
    assign fifo_push = push;

    always_comb begin
        gnt     = '0;
        fifo_wd = '0;
        fifo_id = '0;
        if (push) begin
            gnt[sel_idx] = 1'b1;
            fifo_wd      = wdata[int'(sel_idx)*WIDTH +: WIDTH];
            fifo_id      = sel_idx;
        end
    end

    // Reset owner is the last index so requester 0 wins the first search.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_owner <= ID_W'(N_REQ - 1);
            push_cnt   <= '0;
        end else if (push) begin
            last_owner <= sel_idx;
            push_cnt   <= push_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_push_arb.sv
// Self-checking bench for fifo_push_arb (N_REQ=4, WIDTH=8, MAX_BURST=4).
// Latency: expects zero-cycle grant; outputs sampled on the falling edge.
// Backpressure: exercises fifo_full stalls and reset during traffic.
module tb_fifo_push_arb;

    localparam int N_REQ     = 4;
    localparam int WIDTH     = 8;
    localparam int MAX_BURST = 4;

    logic                   clk = 1'b0;
    logic                   rstn = 1'b0;
    logic [N_REQ-1:0]       req = '0;
    logic [N_REQ*WIDTH-1:0] wdata = '0;
    logic [N_REQ-1:0]       gnt;
    logic                   fifo_full = 1'b0;
    logic                   fifo_push;
    logic [WIDTH-1:0]       fifo_wd;
    logic [1:0]             fifo_id;
    logic [15:0]            push_cnt;

    fifo_push_arb #(
        .N_REQ     (N_REQ),
        .WIDTH     (WIDTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req       (req),
        .wdata     (wdata),
        .gnt       (gnt),
        .fifo_full (fifo_full),
        .fifo_push (fifo_push),
        .fifo_wd   (fifo_wd),
        .fifo_id   (fifo_id),
        .push_cnt  (push_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       push;
        int         id;
        logic [7:0] wd;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [15:0] exp_cnt  = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock of stimulus: drive after the rising edge, queue the expected
    // result, then pop and compare on the falling edge.
    task automatic step(input logic [3:0] r, input logic f, input logic ep, input int eid);
        exp_t e;
        logic [3:0] c4;
        @(posedge clk);
        #1;
        c4        = cyc[3:0];
        req       = r;
        fifo_full = f;
        for (int i = 0; i < N_REQ; i++) begin
            wdata[i*WIDTH +: WIDTH] = {c4, 4'(i)};
        end
        exp_q.push_back('{push: ep, id: eid, wd: (ep ? {c4, 4'(eid)} : 8'h00)});
        @(negedge clk);
        e = exp_q.pop_front();
        check("push", 32'(fifo_push), 32'(e.push));
        check("id",   32'(fifo_id),   e.push ? 32'(e.id) : 32'd0);
        check("wd",   32'(fifo_wd),   32'(e.wd));
        check("gnt",  32'(gnt),       e.push ? (32'd1 << e.id) : 32'd0);
        check("cnt",  32'(push_cnt),  32'(exp_cnt));
        if (e.push) begin
            exp_cnt = exp_cnt + 16'd1;
        end
        cyc++;
    endtask

    // Hold reset with all requesters active: nothing may be pushed.
    task automatic do_reset();
        @(posedge clk);
        #1;
        rstn      = 1'b0;
        req       = 4'b1111;
        fifo_full = 1'b0;
        @(negedge clk);
        check("rst_push", 32'(fifo_push), 32'd0);
        check("rst_gnt",  32'(gnt),       32'd0);
        check("rst_id",   32'(fifo_id),   32'd0);
        check("rst_wd",   32'(fifo_wd),   32'd0);
        check("rst_cnt",  32'(push_cnt),  32'd0);
        @(posedge clk);
        #1;
        req     = '0;
        rstn    = 1'b1;
        exp_cnt = '0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        do_reset();

        // Idle after reset: no request, no push.
        step(4'b0000, 1'b0, 1'b0, 0);

`ifndef FIFO_PUSH_ARB_BURST_EN
        // All requesting: plain rotation 0..3 twice.
        for (int k = 0; k < 8; k++) begin
            step(4'b1111, 1'b0, 1'b1, k % 4);
        end
        step(4'b0000, 1'b0, 1'b0, 0);
        check("cnt_after_8", 32'(push_cnt), 32'd8);

        // Full stalls three cycles, then alternation 0,2,0.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            step(4'b0101, 1'b1, 1'b0, 0);
        end
        step(4'b0101, 1'b0, 1'b1, 0);
        step(4'b0101, 1'b0, 1'b1, 2);
        step(4'b0101, 1'b0, 1'b1, 0);

        // A dropped request is ineligible immediately.
        step(4'b1111, 1'b0, 1'b1, 1);
        step(4'b1001, 1'b0, 1'b1, 3);
`else
        // Bursts of four alternate between the two requesters.
        do_reset();
        for (int k = 0; k < 4; k++) step(4'b0011, 1'b0, 1'b1, 0);
        for (int k = 0; k < 4; k++) step(4'b0011, 1'b0, 1'b1, 1);
        step(4'b0011, 1'b0, 1'b1, 0);

        // Owner 2 leaves after two pushes; requester 3 is next.
        do_reset();
        step(4'b1100, 1'b0, 1'b1, 2);
        step(4'b1100, 1'b0, 1'b1, 2);
        step(4'b1000, 1'b0, 1'b1, 3);

        // A full stall keeps the owner and its burst count.
        do_reset();
        step(4'b0011, 1'b0, 1'b1, 0);
        step(4'b0011, 1'b0, 1'b1, 0);
        step(4'b0011, 1'b1, 1'b0, 0);
        step(4'b0011, 1'b0, 1'b1, 0);
        step(4'b0011, 1'b0, 1'b1, 0);
        step(4'b0011, 1'b0, 1'b1, 1);
`endif

        // Reset in the middle of owner 1 traffic; requester 0 wins afterwards.
        do_reset();
        step(4'b0010, 1'b0, 1'b1, 1);
        step(4'b0010, 1'b0, 1'b1, 1);
        do_reset();
        step(4'b1111, 1'b0, 1'b1, 0);

        // Counter wrap: 65535 pushes from a lone requester, then one more.
        do_reset();
        @(posedge clk);
        #1;
        req = 4'b0001;
        repeat (65535) @(posedge clk);
        #1;
        req     = 4'b0000;
        exp_cnt = 16'hFFFF;
        step(4'b0001, 1'b0, 1'b1, 0);
        step(4'b0000, 1'b0, 1'b0, 0);
        check("cnt_wrap", 32'(push_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_push_arb.md
FIFO_PUSH_ARB -- requirements
Module: fifo_push_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 4, meaning number of requesters (2..16).
REQ-002 SHALL have parameter WIDTH, default 8, meaning data width per requester.
REQ-003 SHALL have parameter MAX_BURST, default 4, meaning maximum consecutive pushes per owner when bursting (1..16).
REQ-004 SHALL have port clk  input  1  clock, rising-edge.
REQ-005 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req  input  N_REQ  per-requester push request.
REQ-007 SHALL have port wdata  input  N_REQ*WIDTH  packed requester data, requester i at bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port gnt  output  N_REQ  one-hot grant; a requester's push is accepted in the cycle its gnt bit is 1.
REQ-009 SHALL have port fifo_full  input  1  full flag of the shared downstream FIFO.
REQ-010 SHALL have port fifo_push  output  1  push strobe to the shared FIFO.
REQ-011 SHALL have port fifo_wd  output  WIDTH  data to the shared FIFO.
REQ-012 SHALL have port fifo_id  output  ID_W  index of the granted requester, ID_W = max(1, clog2(N_REQ)).
REQ-013 SHALL have port push_cnt  output  16  total accepted pushes, wrapping modulo 2^16.

Function
REQ-014 SHALL compute gnt, fifo_push, fifo_wd and fifo_id combinationally in the same cycle from req, fifo_full and registered state (zero-latency grant).
REQ-015 SHALL drive gnt to all-zero and fifo_push to 0 whenever fifo_full=1 or req is all-zero.
REQ-016 SHALL assert at most one gnt bit per cycle; fifo_push SHALL equal the OR of gnt.
REQ-017 SHALL drive fifo_wd = wdata slice and fifo_id = index of the granted requester when fifo_push=1, and 0 on both otherwise.
REQ-018 SHALL select requesters round-robin: the search starts at last_owner+1, wraps from N_REQ-1 to 0, and picks the first asserted req.
REQ-019 SHALL update last_owner to the granted index on every clock edge with fifo_push=1 and hold it otherwise.
REQ-020 SHALL increment push_cnt by 1 on every edge with fifo_push=1, wrapping 0xFFFF to 0x0000.
REQ-021 SHALL, with a single active requester and fifo_full=0, grant it every cycle (one push per clock).
REQ-022 SHALL treat a requester that deasserts req as ineligible that same cycle, with no pending state retained.

Reset
REQ-023 SHALL, while rstn=0, set last_owner=N_REQ-1 (so requester 0 wins first), burst count=0, owner-valid=0 and push_cnt=0.
REQ-024 SHALL, with the state held at its reset values, produce gnt=0, fifo_push=0, fifo_wd=0 and fifo_id=0 when req=0; on the first cycle after reset, requester 0 has highest priority.
REQ-025 SHALL abandon any burst in progress when reset is asserted mid-operation; no push is issued while rstn=0.

Configuration
REQ-026 SHALL, when macro FIFO_PUSH_ARB_BURST_EN is defined, keep the grant on the current owner while its req=1, fifo_full=0 and fewer than MAX_BURST consecutive pushes have been made, then rotate per REQ-018.
REQ-027 SHALL, under FIFO_PUSH_ARB_BURST_EN, neither reset nor advance the burst count on a cycle where fifo_full=1 and the owner's req=1; the owner keeps ownership.
REQ-028 SHALL, under FIFO_PUSH_ARB_BURST_EN, end the burst when the owner's req falls; the next grant follows REQ-018 from that owner.
REQ-029 SHALL, without FIFO_PUSH_ARB_BURST_EN, rotate after every push (MAX_BURST ignored) and contain no burst-count register.

Structure
REQ-030 SHALL take ID_W, the clog2 helper and the push_cnt width constant (16) from shared package fifo_arb_pkg.
REQ-031 SHALL place the rotate-and-pick logic in sub-module rr_pick (inputs: req vector and start index; outputs: found flag and index), instantiated once.

Verification
REQ-032 SHALL verify: N_REQ=4, req=4'b1111 held for 8 cycles, fifo_full=0, burst off -> fifo_id sequence 0,1,2,3,0,1,2,3 and push_cnt=8.
REQ-033 SHALL verify: req=4'b0101, fifo_full=1 for 3 cycles then 0 -> gnt=0 for 3 cycles, then ids 0,2,0.
REQ-034 SHALL verify: burst on, MAX_BURST=4, req=4'b0011 held -> ids 0,0,0,0,1,1,1,1,0.
REQ-035 SHALL verify: burst on, owner 2 drops req after 2 pushes while req[3]=1 -> the next grant goes to id 3.
REQ-036 SHALL verify: push_cnt preloaded via 65535 pushes, then 1 more push -> push_cnt=0.
REQ-037 SHALL verify: rstn pulsed low mid-burst (owner 1) -> outputs go to 0 and the first grant after release goes to requester 0 when req=4'b1111.
